// File: rtl/cpu_fetch_s.sv
// Instruction fetch stage: owns the PC, keeps one L1 read in flight and buffers words for decode.
// Build option FETCH_PERF_EN adds saturating stall/kill event counters as extra outputs.
module cpu_fetch_s #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        fetch_clk,
    input  logic        fetch_rst,
    output logic        fetch_il1_req,
    output logic [31:0] fetch_il1_addr,
    input  logic        fetch_il1_ack,
    input  logic [31:0] fetch_il1_data,
    input  logic        fetch_stall,
    input  logic        fetch_kill,
    input  logic [31:0] fetch_redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_perf_stall_cnt,
    output logic [31:0] fetch_perf_kill_cnt
`endif
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_DROP
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        target_q, target_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]        fifo_inst_q [FIFO_DEPTH];

    logic               ack_ok;
    logic               fifo_valid;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_after;
    logic               slot_free;
    logic [31:0]        redirect_aligned;

    // ack only counts while a request is actually on the bus
    assign ack_ok           = req_q && fetch_il1_ack;
    assign fifo_valid       = (count_q != '0);
    assign push             = ack_ok && (state_q == ST_REQ) && !fetch_kill;
    assign pop              = fifo_valid && !fetch_stall && !fetch_kill;
    assign count_after      = count_q + CNT_W'(push) - CNT_W'(pop);
    assign slot_free        = (count_after < FULL_CNT);
    assign redirect_aligned = fetch_redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_after;

        if (fetch_kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (req_q && !fetch_il1_ack) begin
                // Request still in flight: keep its address on the bus until the L1 answers.
                state_d  = ST_DROP;
                target_d = redirect_aligned;
            end else begin
                state_d = ST_REQ;
                addr_d  = redirect_aligned;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (push) begin
                        addr_d  = addr_q + 32'd4;
                        state_d = slot_free ? ST_REQ : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (slot_free) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (ack_ok) begin
                        state_d = ST_REQ;
                        addr_d  = target_q;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end

        req_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge fetch_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (fetch_rst) begin
            state_q  <= ST_REQ;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: buffer storage is not reset; entries are only observed once count_q marks them valid.
    always_ff @(posedge fetch_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= addr_q;
            fifo_inst_q[wr_ptr_q] <= fetch_il1_data;
        end
    end

    assign fetch_il1_req  = req_q;
    assign fetch_il1_addr = addr_q;
    assign fetch_valid    = fifo_valid;
    assign fetch_inst     = fifo_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
    assign fetch_pc       = fifo_valid ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign fetch_pc_4     = fetch_pc + 32'd4;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (fifo_valid && fetch_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (fetch_kill && (kill_cnt_q != 32'hFFFF_FFFF)) begin
            kill_cnt_d = kill_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge fetch_clk) begin
        if (fetch_rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_perf_stall_cnt = stall_cnt_q;
    assign fetch_perf_kill_cnt  = kill_cnt_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge fetch_clk) begin
        if (!fetch_rst) begin
            assert (!(push && (count_q == FULL_CNT)));
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_s.sv
// Self-checking bench for cpu_fetch_s: directed scenarios plus random traffic against a
// queue-based model of the fetch buffer and PC sequence.
module tb_cpu_fetch_s;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        fetch_rst;
    logic        fetch_il1_req;
    logic [31:0] fetch_il1_addr;
    logic        fetch_il1_ack;
    logic [31:0] fetch_il1_data;
    logic        fetch_stall;
    logic        fetch_kill;
    logic [31:0] fetch_redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_4;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [31:0] w_pc_4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_kill_cnt, w_perf_stall_cnt, w_perf_kill_cnt;
`endif

    always #5 clk = ~clk;

    cpu_fetch_s #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .fetch_clk(clk), .fetch_rst(fetch_rst),
        .fetch_il1_req(fetch_il1_req), .fetch_il1_addr(fetch_il1_addr),
        .fetch_il1_ack(fetch_il1_ack), .fetch_il1_data(fetch_il1_data),
        .fetch_stall(fetch_stall), .fetch_kill(fetch_kill),
        .fetch_redirect_pc(fetch_redirect_pc),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
        .fetch_pc(fetch_pc), .fetch_pc_4(fetch_pc_4)
`ifdef FETCH_PERF_EN
        , .fetch_perf_stall_cnt(perf_stall_cnt), .fetch_perf_kill_cnt(perf_kill_cnt)
`endif
    );

    // Second instance starts near the top of the address space; its L1 acks every request.
    assign w_ack = w_req;

    cpu_fetch_s #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut_w (
        .fetch_clk(clk), .fetch_rst(fetch_rst),
        .fetch_il1_req(w_req), .fetch_il1_addr(w_addr),
        .fetch_il1_ack(w_ack), .fetch_il1_data(w_addr),
        .fetch_stall(1'b0), .fetch_kill(1'b0),
        .fetch_redirect_pc(32'h0000_0000),
        .fetch_valid(w_valid), .fetch_inst(w_inst),
        .fetch_pc(w_pc), .fetch_pc_4(w_pc_4)
`ifdef FETCH_PERF_EN
        , .fetch_perf_stall_cnt(w_perf_stall_cnt), .fetch_perf_kill_cnt(w_perf_kill_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: ordered list of fetched words, next PC, and a pending-discard marker.
    logic [31:0] q_pc   [$];
    logic [31:0] q_inst [$];
    logic [31:0] next_pc;
    logic [31:0] drop_addr;
    bit          drop_pend;
    bit          first_cyc;
    int          m_stall;
    int          m_kill;

    logic        exp_req, exp_valid;
    logic [31:0] exp_addr, exp_inst, exp_pc, exp_pc4;

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        next_pc   = 32'h0000_0000;
        drop_addr = 32'h0000_0000;
        drop_pend = 1'b0;
        first_cyc = 1'b1;
        m_stall   = 0;
        m_kill    = 0;
    endtask

    task automatic drive(input logic a, input logic s, input logic k,
                         input logic [31:0] r, input logic [31:0] d);
        fetch_il1_ack     = a;
        fetch_stall       = s;
        fetch_kill        = k;
        fetch_redirect_pc = r;
        fetch_il1_data    = d;
        #1;
        exp_req   = first_cyc ? 1'b0 : (drop_pend || (q_pc.size() < DEPTH));
        exp_addr  = drop_pend ? drop_addr : next_pc;
        exp_valid = (q_pc.size() != 0);
        exp_inst  = exp_valid ? q_inst[0] : NOP;
        exp_pc    = exp_valid ? q_pc[0] : 32'h0000_0000;
        exp_pc4   = exp_pc + 32'd4;
    endtask

    task automatic advance();
        bit took;
        took = exp_req && fetch_il1_ack;
        if (exp_valid && fetch_stall) m_stall++;
        if (fetch_kill) begin
            m_kill++;
            q_pc.delete();
            q_inst.delete();
            drop_pend = exp_req && !took;
            drop_addr = exp_addr;
            next_pc   = fetch_redirect_pc & ~32'h3;
        end else begin
            if (exp_valid && !fetch_stall) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (took) begin
                if (drop_pend) begin
                    drop_pend = 1'b0;
                end else begin
                    q_pc.push_back(exp_addr);
                    q_inst.push_back(fetch_il1_data);
                    next_pc = next_pc + 32'd4;
                end
            end
        end
        first_cyc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_rst         = 1'b1;
        fetch_il1_ack     = 1'b0;
        fetch_il1_data    = 32'h0;
        fetch_stall       = 1'b0;
        fetch_kill        = 1'b0;
        fetch_redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        fetch_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (fetch_il1_req !== 1'b0) $display("FAIL reset_req: got %b want 0", fetch_il1_req); else n_pass++;
        n_total++; if (fetch_il1_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", fetch_il1_addr); else n_pass++;
        n_total++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fetch_valid); else n_pass++;
        n_total++; if (fetch_inst !== NOP) $display("FAIL reset_inst: got %h want %h", fetch_inst, NOP); else n_pass++;
        n_total++; if (fetch_pc !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", fetch_pc); else n_pass++;
        n_total++; if (fetch_pc_4 !== 32'h4) $display("FAIL reset_pc_4: got %h want 00000004", fetch_pc_4); else n_pass++;
`ifdef FETCH_PERF_EN
        n_total++; if (perf_stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt: got %0d want 0", perf_stall_cnt); else n_pass++;
        n_total++; if (perf_kill_cnt !== 32'h0) $display("FAIL reset_kill_cnt: got %0d want 0", perf_kill_cnt); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
            n_total++; if (fetch_il1_req !== (c >= 1)) $display("FAIL stream_req c%0d: got %b want %b", c, fetch_il1_req, (c >= 1)); else n_pass++;
            if (c >= 1) begin
                n_total++; if (fetch_il1_addr !== 32'(4 * (c - 1))) $display("FAIL stream_addr c%0d: got %h want %h", c, fetch_il1_addr, 32'(4 * (c - 1))); else n_pass++;
            end
            n_total++; if (fetch_valid !== (c >= 2)) $display("FAIL stream_valid c%0d: got %b want %b", c, fetch_valid, (c >= 2)); else n_pass++;
            if (c >= 2) begin
                n_total++; if (fetch_pc !== 32'(4 * (c - 2))) $display("FAIL stream_pc c%0d: got %h want %h", c, fetch_pc, 32'(4 * (c - 2))); else n_pass++;
                n_total++; if (fetch_pc_4 !== 32'(4 * (c - 1))) $display("FAIL stream_pc_4 c%0d: got %h want %h", c, fetch_pc_4, 32'(4 * (c - 1))); else n_pass++;
                n_total++; if (fetch_inst !== exp_inst) $display("FAIL stream_inst c%0d: got %h want %h", c, fetch_inst, exp_inst); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_stall_fill();
        int popped = 0;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            logic s;
            s = (c >= 2) && (c < 8);
            drive(1'b1, s, 1'b0, 32'h0, $urandom);
            n_total++; if (fetch_il1_req !== exp_req) $display("FAIL fill_req c%0d: got %b want %b", c, fetch_il1_req, exp_req); else n_pass++;
            if (c == 7) begin
                n_total++; if (fetch_il1_req !== 1'b0) $display("FAIL fill_hold c%0d: got req %b want 0", c, fetch_il1_req); else n_pass++;
            end
            n_total++; if (fetch_valid !== exp_valid) $display("FAIL fill_valid c%0d: got %b want %b", c, fetch_valid, exp_valid); else n_pass++;
            if (fetch_valid && !s) begin
                n_total++; if (fetch_pc !== 32'(4 * popped)) $display("FAIL fill_order c%0d: got pc %h want %h", c, fetch_pc, 32'(4 * popped)); else n_pass++;
                n_total++; if (fetch_inst !== exp_inst) $display("FAIL fill_inst c%0d: got %h want %h", c, fetch_inst, exp_inst); else n_pass++;
                popped++;
            end
            advance();
        end
        n_total++; if (popped < 8) $display("FAIL fill_progress: got %0d words want at least 8", popped); else n_pass++;
    endtask

    task automatic test_kill_drop();
        bit found = 1'b0;
        do_reset();
        for (int c = 0; c < 20 && !found; c++) begin
            if (fetch_il1_req && (fetch_il1_addr == 32'h10)) found = 1'b1;
            else begin
                drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
                advance();
            end
        end
        n_total++; if (!found) $display("FAIL drop_reach: got no request to 00000010 want one"); else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(c == 2, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
            n_total++; if (fetch_valid !== 1'b0) $display("FAIL drop_valid c%0d: got %b want 0", c, fetch_valid); else n_pass++;
            n_total++; if (fetch_il1_req !== 1'b1) $display("FAIL drop_req c%0d: got %b want 1", c, fetch_il1_req); else n_pass++;
            n_total++; if (fetch_il1_addr !== 32'h10) $display("FAIL drop_addr c%0d: got %h want 00000010", c, fetch_il1_addr); else n_pass++;
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
        n_total++; if (fetch_il1_addr !== 32'h200) $display("FAIL drop_target: got %h want 00000200", fetch_il1_addr); else n_pass++;
        n_total++; if (fetch_valid !== 1'b0) $display("FAIL drop_stale: got valid %b want 0", fetch_valid); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (fetch_pc !== 32'h200) $display("FAIL drop_first_pc: got %h want 00000200", fetch_pc); else n_pass++;
        n_total++; if (fetch_inst !== exp_inst) $display("FAIL drop_first_inst: got %h want %h", fetch_inst, exp_inst); else n_pass++;
        advance();
    endtask

    task automatic test_kill_ack();
        bit found = 1'b0;
        do_reset();
        for (int c = 0; c < 20 && !found; c++) begin
            if (fetch_il1_req && (fetch_il1_addr == 32'h8)) found = 1'b1;
            else begin
                drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
                advance();
            end
        end
        n_total++; if (!found) $display("FAIL killack_reach: got no request to 00000008 want one"); else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
        n_total++; if (fetch_valid !== 1'b0) $display("FAIL killack_valid: got %b want 0", fetch_valid); else n_pass++;
        n_total++; if (fetch_il1_req !== 1'b1) $display("FAIL killack_req: got %b want 1", fetch_il1_req); else n_pass++;
        n_total++; if (fetch_il1_addr !== 32'h40) $display("FAIL killack_addr: got %h want 00000040", fetch_il1_addr); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (fetch_pc !== 32'h40) $display("FAIL killack_pc: got %h want 00000040", fetch_pc); else n_pass++;
        n_total++; if (fetch_pc_4 !== 32'h44) $display("FAIL killack_pc_4: got %h want 00000044", fetch_pc_4); else n_pass++;
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (fetch_il1_addr !== 32'hC) $display("FAIL rstmid_pre_addr: got %h want 0000000c", fetch_il1_addr); else n_pass++;
        fetch_rst     = 1'b1;
        fetch_il1_ack = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (fetch_il1_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", fetch_il1_req); else n_pass++;
        n_total++; if (fetch_il1_addr !== 32'h0) $display("FAIL rstmid_addr: got %h want 00000000", fetch_il1_addr); else n_pass++;
        n_total++; if (fetch_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", fetch_valid); else n_pass++;
        fetch_rst = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_BAD0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (fetch_valid !== 1'b0) $display("FAIL rstmid_late_ack: got valid %b want 0", fetch_valid); else n_pass++;
        n_total++; if (fetch_il1_req !== 1'b1) $display("FAIL rstmid_restart_req: got %b want 1", fetch_il1_req); else n_pass++;
        n_total++; if (fetch_il1_addr !== 32'h0) $display("FAIL rstmid_restart_addr: got %h want 00000000", fetch_il1_addr); else n_pass++;
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic        a, s, k;
            logic [31:0] r;
            a = fetch_il1_req && ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) < 4);
            k = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(a, s, k, r, $urandom);
            n_total++; if (fetch_il1_req !== exp_req) $display("FAIL rand_req c%0d: got %b want %b", c, fetch_il1_req, exp_req); else n_pass++;
            n_total++; if (fetch_il1_addr !== exp_addr) $display("FAIL rand_addr c%0d: got %h want %h", c, fetch_il1_addr, exp_addr); else n_pass++;
            n_total++; if (fetch_valid !== exp_valid) $display("FAIL rand_valid c%0d: got %b want %b", c, fetch_valid, exp_valid); else n_pass++;
            n_total++; if (fetch_inst !== exp_inst) $display("FAIL rand_inst c%0d: got %h want %h", c, fetch_inst, exp_inst); else n_pass++;
            n_total++; if (fetch_pc !== exp_pc) $display("FAIL rand_pc c%0d: got %h want %h", c, fetch_pc, exp_pc); else n_pass++;
            n_total++; if (fetch_pc_4 !== exp_pc4) $display("FAIL rand_pc_4 c%0d: got %h want %h", c, fetch_pc_4, exp_pc4); else n_pass++;
`ifdef FETCH_PERF_EN
            n_total++; if (perf_stall_cnt !== 32'(m_stall)) $display("FAIL rand_stall_cnt c%0d: got %0d want %0d", c, perf_stall_cnt, m_stall); else n_pass++;
            n_total++; if (perf_kill_cnt !== 32'(m_kill)) $display("FAIL rand_kill_cnt c%0d: got %0d want %0d", c, perf_kill_cnt, m_kill); else n_pass++;
`endif
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [4];
        int          n_req = 0;
        bit          seen_top = 1'b0;
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        want[3] = 32'h0000_0004;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (w_req && (n_req < 4)) begin
                n_total++; if (w_addr !== want[n_req]) $display("FAIL wrap_addr n%0d: got %h want %h", n_req, w_addr, want[n_req]); else n_pass++;
                n_req++;
            end
            if (w_valid && (w_pc == 32'hFFFF_FFFC)) begin
                seen_top = 1'b1;
                n_total++; if (w_pc_4 !== 32'h0) $display("FAIL wrap_pc_4: got %h want 00000000", w_pc_4); else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        n_total++; if (n_req != 4) $display("FAIL wrap_count: got %0d requests want 4", n_req); else n_pass++;
        n_total++; if (!seen_top) $display("FAIL wrap_top: got no word at fffffffc want one"); else n_pass++;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);       advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, $urandom);    advance();
        drive(1'b1, 1'b1, 1'b0, 32'h0, $urandom);    advance();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);       advance();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);       advance();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);     advance();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);     advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (perf_stall_cnt !== 32'd3) $display("FAIL perf_stall_cnt: got %0d want 3", perf_stall_cnt); else n_pass++;
        n_total++; if (perf_kill_cnt !== 32'd2) $display("FAIL perf_kill_cnt: got %0d want 2", perf_kill_cnt); else n_pass++;
        fetch_rst = 1'b1;
        @(posedge clk);
        #1;
        fetch_rst = 1'b0;
        n_total++; if (perf_stall_cnt !== 32'd0) $display("FAIL perf_stall_clr: got %0d want 0", perf_stall_cnt); else n_pass++;
        n_total++; if (perf_kill_cnt !== 32'd0) $display("FAIL perf_kill_clr: got %0d want 0", perf_kill_cnt); else n_pass++;
        model_reset();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_kill_drop();
        test_kill_ack();
        test_reset_mid();
        test_random();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
